// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, EX-stage resolution and statistics
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_x70,
  input  logic             rst_x70,
  input  logic [31:0]      if_pc_x70,
  output logic             pred_taken_x70,
  output logic [31:0]      pred_target_x70,
  input  logic             ex_valid_x70,
  input  logic             ex_is_branch_x70,
  input  logic [31:0]      ex_pc_x70,
  input  logic             ex_taken_x70,
  input  logic [31:0]      ex_target_x70,
  input  logic             ex_pred_taken_x70,
  input  logic [31:0]      ex_pred_target_x70,
  output logic             mispredict_x70,
  output logic [31:0]      redirect_pc_x70,
  output logic [CNT_W-1:0] branch_cnt_x70,
  output logic [CNT_W-1:0] mispred_cnt_x70
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  logic          vld [ENTRIES];
  logic [TW-1:0] tag [ENTRIES];
  logic [31:0]   tgt [ENTRIES];
  logic [1:0]    ctr [ENTRIES];
  logic [IW-1:0] fi, ei;
  logic          fhit, ehit, upd;
  assign fi = if_pc_x70[IW+1:2];
  assign ei = ex_pc_x70[IW+1:2];
  assign fhit = vld[fi] && tag[fi] == if_pc_x70[31:IW+2];
  assign ehit = vld[ei] && tag[ei] == ex_pc_x70[31:IW+2];
  assign upd = ex_valid_x70 && ex_is_branch_x70;
  always_comb begin
    pred_taken_x70 = fhit && ctr[fi][1];
    pred_target_x70 = pred_taken_x70 ? tgt[fi] : if_pc_x70 + 32'd4;
    mispredict_x70 = upd && (ex_pred_taken_x70 != ex_taken_x70 ||
                     (ex_taken_x70 && ex_pred_target_x70 != ex_target_x70));
    redirect_pc_x70 = ex_taken_x70 ? ex_target_x70 : ex_pc_x70 + 32'd4;
  end
  always_ff @(posedge clk_x70) begin
    if (rst_x70) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld[i] <= 1'b0;
        tag[i] <= '0;
        tgt[i] <= '0;
        ctr[i] <= 2'b01;
      end
      branch_cnt_x70 <= '0;
      mispred_cnt_x70 <= '0;
    end else begin
      if (upd && ehit) begin
        ctr[ei] <= ex_taken_x70 ? (ctr[ei] == 2'b11 ? 2'b11 : ctr[ei] + 2'b01)
                                : (ctr[ei] == 2'b00 ? 2'b00 : ctr[ei] - 2'b01);
        if (ex_taken_x70) tgt[ei] <= ex_target_x70;
      end else if (upd && ex_taken_x70) begin
        vld[ei] <= 1'b1;
        tag[ei] <= ex_pc_x70[31:IW+2];
        tgt[ei] <= ex_target_x70;
        ctr[ei] <= 2'b10;
      end
      if (upd && !(&branch_cnt_x70)) branch_cnt_x70 <= branch_cnt_x70 + CNT_W'(1);
      if (mispredict_x70 && !(&mispred_cnt_x70)) mispred_cnt_x70 <= mispred_cnt_x70 + CNT_W'(1);
    end
  end
endmodule
